// File: rtl/imm_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module  : imm_chunk_seq
// Brief   : Assembles an 8-bit signed immediate from 2-bit chunks; the first
//           chunk goes through an external sign extender, later ones shift in.
// Revision: 1.0 - initial release
// ============================================================================
module imm_chunk_seq #(
    parameter int MAX_CHUNKS = 4            // legal range 1..4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chunk_valid,
    input  logic [1:0] chunk_data,
    input  logic       chunk_last,
    output logic       chunk_ready,
    output logic [1:0] sext_in,
    input  logic [7:0] sext_out,
    output logic       imm_valid,
    output logic [7:0] imm_data,
    output logic       imm_err,
    input  logic       imm_ready
);

    localparam logic [2:0] C_MAX_CNT = 3'(MAX_CHUNKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       w_accept;

    assign sext_in  = chunk_data;
    assign w_accept = chunk_valid & chunk_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        chunk_ready = 1'b0;
        imm_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                chunk_ready = 1'b1;
                if (w_accept) begin
                    acc_d = sext_out;
                    cnt_d = 3'd1;
                    if (chunk_last) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else if (C_MAX_CNT == 3'd1) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                chunk_ready = 1'b1;
                if (w_accept) begin
                    // Plain logical shift: bits above the 8-bit window drop off.
                    acc_d = {acc_q[5:0], chunk_data};
                    cnt_d = cnt_q + 3'd1;
                    if (chunk_last) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else if (cnt_q + 3'd1 == C_MAX_CNT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                imm_valid = 1'b1;
                if (imm_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: recover to the reset condition.
                state_d = S_IDLE;
                acc_d   = 8'h00;
                cnt_d   = 3'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign imm_data = acc_q;
    assign imm_err  = imm_valid & err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_chunk_seq
// Brief   : Directed self-checking bench for imm_chunk_seq.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imm_chunk_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       chunk_valid;
    logic [1:0] chunk_data;
    logic       chunk_last;
    logic       chunk_ready;
    logic [1:0] sext_in;
    logic [7:0] sext_out;
    logic       imm_valid;
    logic [7:0] imm_data;
    logic       imm_err;
    logic       imm_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External 2-to-8 sign extender
    assign sext_out = {{6{sext_in[1]}}, sext_in};

    imm_chunk_seq #(.MAX_CHUNKS(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .chunk_valid (chunk_valid),
        .chunk_data  (chunk_data),
        .chunk_last  (chunk_last),
        .chunk_ready (chunk_ready),
        .sext_in     (sext_in),
        .sext_out    (sext_out),
        .imm_valid   (imm_valid),
        .imm_data    (imm_data),
        .imm_err     (imm_err),
        .imm_ready   (imm_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d, input logic last);
        int waited = 0;
        chunk_valid = 1'b1;
        chunk_data  = d;
        chunk_last  = last;
        while (!chunk_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("send_timeout", 32'd1, 32'd0);
        tick();
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
    endtask

    task automatic take();
        imm_ready = 1'b1;
        tick();
        imm_ready = 1'b0;
        check("take_valid_drop", imm_valid, 1'b0);
        check("take_ready_back", chunk_ready, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        chunk_valid = 1'b0;
        chunk_data  = 2'b00;
        chunk_last  = 1'b0;
        imm_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_chunk_ready", chunk_ready, 1'b1);
        check("rst_imm_valid", imm_valid, 1'b0);
        check("rst_imm_data", imm_data, 8'h00);
        check("rst_imm_err", imm_err, 1'b0);
        check("sext_passthru", sext_in, 2'b00);

        // Single chunk, last: sign-extended 10 -> FE
        send(2'b10, 1'b1);
        check("t1_valid", imm_valid, 1'b1);
        check("t1_data", imm_data, 8'hFE);
        check("t1_err", imm_err, 1'b0);
        check("t1_ready_low", chunk_ready, 1'b0);
        take();

        // 01, 11 -> 07
        send(2'b01, 1'b0);
        check("t2_mid_valid", imm_valid, 1'b0);
        send(2'b11, 1'b1);
        check("t2_valid", imm_valid, 1'b1);
        check("t2_data", imm_data, 8'h07);
        check("t2_err", imm_err, 1'b0);
        take();

        // Four chunks, no last: 10,00,01,11 -> 87 with error
        send(2'b10, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        check("t3_not_yet", imm_valid, 1'b0);
        send(2'b11, 1'b0);
        check("t3_valid", imm_valid, 1'b1);
        check("t3_data", imm_data, 8'h87);
        check("t3_err", imm_err, 1'b1);

        // Hold in DONE with a chunk pending and no consumer
        chunk_valid = 1'b1;
        chunk_data  = 2'b01;
        chunk_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", imm_valid, 1'b1);
            check("t4_hold_data", imm_data, 8'h87);
            check("t4_hold_err", imm_err, 1'b1);
            check("t4_no_ready", chunk_ready, 1'b0);
        end
        // Handoff with chunk still offered: must not be accepted in the same cycle
        imm_ready = 1'b1;
        tick();
        imm_ready = 1'b0;
        check("t4_no_bypass_valid", imm_valid, 1'b0);
        check("t4_no_bypass_data", imm_data, 8'h87);
        tick();
        check("t4_next_accept_valid", imm_valid, 1'b1);
        check("t4_next_accept_data", imm_data, 8'h01);
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
        take();

        // Reset mid-immediate
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", imm_valid, 1'b0);
        check("t5_data", imm_data, 8'h00);
        check("t5_ready", chunk_ready, 1'b1);
        send(2'b11, 1'b1);
        check("t5_fresh_valid", imm_valid, 1'b1);
        check("t5_fresh_data", imm_data, 8'hFF);
        take();

        // Gaps in chunk_valid between chunks
        send(2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_gap_valid", imm_valid, 1'b0);
            check("t6_gap_ready", chunk_ready, 1'b1);
            check("t6_gap_data", imm_data, 8'h00);
        end
        send(2'b01, 1'b1);
        check("t6_valid", imm_valid, 1'b1);
        check("t6_data", imm_data, 8'h01);
        check("t6_err", imm_err, 1'b0);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
